// File: rtl/nand_flash_responder.sv
// Pin-level NAND flash target: command/address/data decode, page array, page register, busy on F_RB.
// Define NAND_RESP_STATUS_EN to build the 70h status command and its STATUS state.
module nand_flash_responder #(
    parameter int PAGE_BYTES = 512,
    parameter int PAGES      = 64,
    parameter int T_EXTRA    = 16
) (
    input  logic       clk,
    input  logic       rst,
    inout  wire  [7:0] F_IO,
    input  logic       F_CLE,
    input  logic       F_ALE,
    input  logic       F_WEN,
    input  logic       F_REN,
    output logic       F_RB
);
    localparam int PW = $clog2(PAGE_BYTES);
    localparam int GW = $clog2(PAGES);
    localparam int CW = $clog2(PAGE_BYTES + T_EXTRA + 1);

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_ADDR     = 3'd1;
    localparam logic [2:0] ST_BUSY_RD  = 3'd2;
    localparam logic [2:0] ST_DATA_OUT = 3'd3;
    localparam logic [2:0] ST_DATA_IN  = 3'd4;
    localparam logic [2:0] ST_BUSY_PG  = 3'd5;
    localparam logic [2:0] ST_BUSY_RST = 3'd6;
`ifdef NAND_RESP_STATUS_EN
    localparam logic [2:0] ST_STATUS   = 3'd7;
`endif

    logic          wen_q, wen_prev_q, ren_q, ren_prev_q, cle_q, ale_q;
    logic [7:0]    io_q;
    logic [2:0]    state_q, state_d, bstate;
    logic [PW-1:0] ptr_q, ptr_d, start_q, start_d;
    logic [GW-1:0] page_q, page_d;
    logic [7:0]    plo_q, plo_d;
    logic [1:0]    acnt_q, acnt_d;
    logic [CW-1:0] cnt_q, cnt_d, busy_last;
    logic          base_q, base_d, prog_q, prog_d;
    logic          oe_q, oe_d;
    logic [7:0]    dout_q, dout_d;
    logic          wen_rise, ren_rise, is_cmd, is_addr, is_data;
    logic          busy_done, rd_copy, pg_copy, clear_pr;
    logic [15:0]   col_full, pg16;
    logic          unused_bits;
`ifdef NAND_RESP_STATUS_EN
    logic [2:0]    ret_q, ret_d;
`endif

    logic [7:0] arr_q  [PAGES*PAGE_BYTES];
    logic [7:0] preg_q [PAGE_BYTES];

    function automatic logic is_busy(input logic [2:0] s);
        return (s == ST_BUSY_RD) || (s == ST_BUSY_PG) || (s == ST_BUSY_RST);
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wen_q      <= 1'b1;
            wen_prev_q <= 1'b1;
            ren_q      <= 1'b1;
            ren_prev_q <= 1'b1;
            cle_q      <= 1'b0;
            ale_q      <= 1'b0;
            io_q       <= 8'h00;
        end else begin
            wen_q      <= F_WEN;
            wen_prev_q <= wen_q;
            ren_q      <= F_REN;
            ren_prev_q <= ren_q;
            cle_q      <= F_CLE;
            ale_q      <= F_ALE;
            io_q       <= F_IO;
        end
    end

    // A WEN rise wins over a REN rise in the same cycle.
    assign wen_rise = wen_q & ~wen_prev_q;
    assign ren_rise = ren_q & ~ren_prev_q & ~wen_rise;
    assign is_cmd   = wen_rise &  cle_q & ~ale_q;
    assign is_addr  = wen_rise & ~cle_q &  ale_q;
    assign is_data  = wen_rise & ~cle_q & ~ale_q;

`ifdef NAND_RESP_STATUS_EN
    assign bstate = (state_q == ST_STATUS) ? ret_q : state_q;
`else
    assign bstate = state_q;
`endif

    assign busy_last   = (bstate == ST_BUSY_RST) ? CW'(T_EXTRA - 1) : CW'(PAGE_BYTES + T_EXTRA - 1);
    assign busy_done   = is_busy(bstate) && (cnt_q == busy_last);
    assign rd_copy     = (bstate == ST_BUSY_RD) && (cnt_q < CW'(PAGE_BYTES));
    assign pg_copy     = (bstate == ST_BUSY_PG) && (cnt_q < CW'(PAGE_BYTES));
    assign col_full    = {7'd0, base_q, io_q};
    assign pg16        = {io_q, plo_q};
    assign unused_bits = ^{col_full, pg16};
    assign F_RB        = ~is_busy(bstate);
    assign F_IO        = oe_q ? dout_q : 8'hzz;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        state_d  = state_q;
        ptr_d    = ptr_q;
        start_d  = start_q;
        page_d   = page_q;
        plo_d    = plo_q;
        acnt_d   = acnt_q;
        cnt_d    = cnt_q;
        base_d   = base_q;
        prog_d   = prog_q;
        clear_pr = 1'b0;
`ifdef NAND_RESP_STATUS_EN
        ret_d    = ret_q;
`endif
        // Busy operations keep counting even while a status read is in progress.
        if (is_busy(bstate)) begin
            cnt_d = cnt_q + 1'b1;
            if (busy_done) begin
                ptr_d = start_q;
`ifdef NAND_RESP_STATUS_EN
                if (state_q == ST_STATUS) ret_d = ST_IDLE;
                else
`endif
                state_d = (bstate == ST_BUSY_RD) ? ST_DATA_OUT : ST_IDLE;
            end
        end

        if (is_cmd) begin
            if (io_q == 8'hFF) begin
                state_d = ST_BUSY_RST;
                cnt_d   = '0;
            end
`ifdef NAND_RESP_STATUS_EN
            else if (io_q == 8'h70) begin
                if (state_q != ST_STATUS) ret_d = state_d;
                state_d = ST_STATUS;
            end
`endif
            else if (!is_busy(bstate)) begin
                case (io_q)
                    8'h00, 8'h01: begin
                        state_d = ST_ADDR;
                        base_d  = io_q[0];
                        prog_d  = 1'b0;
                        acnt_d  = '0;
                    end
                    8'h80: begin
                        state_d  = ST_ADDR;
                        base_d   = 1'b0;
                        prog_d   = 1'b1;
                        acnt_d   = '0;
                        clear_pr = 1'b1;
                    end
                    8'h10: begin
                        state_d = (state_q == ST_DATA_IN) ? ST_BUSY_PG : ST_IDLE;
                        cnt_d   = '0;
                    end
                    default: state_d = ST_IDLE;
                endcase
            end
        end else if (is_addr && state_q == ST_ADDR) begin
            acnt_d = acnt_q + 1'b1;
            case (acnt_q)
                2'd0: start_d = col_full[PW-1:0];
                2'd1: plo_d   = io_q;
                default: begin
                    page_d = pg16[GW-1:0];
                    cnt_d  = '0;
                    if (prog_q) begin
                        state_d = ST_DATA_IN;
                        ptr_d   = start_q;
                    end else begin
                        state_d = ST_BUSY_RD;
                    end
                end
            endcase
        end else if (is_data && state_q == ST_DATA_IN) begin
            ptr_d = ptr_q + 1'b1;
        end else if (ren_rise && state_q == ST_DATA_OUT) begin
            ptr_d = ptr_q + 1'b1;
        end
`ifdef NAND_RESP_STATUS_EN
        else if (ren_rise && state_q == ST_STATUS) begin
            state_d = ret_d;
        end
`endif
    end

    always_comb begin
        oe_d   = !ren_q && (state_q == ST_DATA_OUT);
        dout_d = preg_q[ptr_q];
`ifdef NAND_RESP_STATUS_EN
        if (state_q == ST_STATUS) begin
            oe_d   = !ren_q;
            dout_d = is_busy(bstate) ? 8'h80 : 8'hC0;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            start_q <= '0;
            page_q  <= '0;
            plo_q   <= '0;
            acnt_q  <= '0;
            cnt_q   <= '0;
            base_q  <= 1'b0;
            prog_q  <= 1'b0;
            oe_q    <= 1'b0;
            dout_q  <= 8'h00;
`ifdef NAND_RESP_STATUS_EN
            ret_q   <= ST_IDLE;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            start_q <= start_d;
            page_q  <= page_d;
            plo_q   <= plo_d;
            acnt_q  <= acnt_d;
            cnt_q   <= cnt_d;
            base_q  <= base_d;
            prog_q  <= prog_d;
            oe_q    <= oe_d;
            dout_q  <= dout_d;
`ifdef NAND_RESP_STATUS_EN
            ret_q   <= ret_d;
`endif
        end
    end

    // NOTE: storage has no reset; flash contents must survive rst.
    always_ff @(posedge clk) begin
        if (clear_pr) begin
            for (int i = 0; i < PAGE_BYTES; i++) preg_q[i] <= 8'hFF;
        end else if (is_data && state_q == ST_DATA_IN) begin
            preg_q[ptr_q] <= io_q;
        end else if (rd_copy) begin
            preg_q[cnt_q[PW-1:0]] <= arr_q[{page_q, cnt_q[PW-1:0]}];
        end
        if (pg_copy) arr_q[{page_q, cnt_q[PW-1:0]}] <= preg_q[cnt_q[PW-1:0]];
    end
endmodule
